fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register for the MIPS core.

---
 rtl/fetch_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the MIPS core.
// Issues one outstanding fetch, buffers one word across decode stalls, and discards words killed by redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_word_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_req_en;
    logic        r_kill;
    logic [31:0] r_kill_addr;
    logic [31:0] r_pc_f;
    fetch_word_t r_buf;

    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;

    logic        w_accept;
    logic        w_take;
    logic        w_to_ifid;
    logic        w_to_buf;
    logic        w_drain;
    logic [31:0] w_pc_f_plus4;
    logic [31:0] w_buf_pc_plus4;

    // A returned word is live only if it is not the orphan of an earlier redirect
    // and is not overtaken by a redirect in the same cycle.
    assign w_accept       = inst_req && inst_data_ok;
    assign w_take         = w_accept && !r_kill && !redirect_valid;
    assign w_to_ifid      = w_take && !stall_d;
    assign w_to_buf       = w_take && stall_d;
    assign w_drain        = (r_state == S_HOLD) && !stall_d && !redirect_valid;
    assign w_pc_f_plus4   = r_pc_f + 32'd4;
    assign w_buf_pc_plus4 = r_buf.pc + 32'd4;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: every sequential block uses non-blocking assignments so all registers
    // see pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_FETCH: begin
                if (w_to_buf) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || !stall_d) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // While a killed request is still in flight the bus keeps seeing its
    // original address; the redirect target waits in r_pc_f.
    always_comb begin
        inst_req  = 1'b0;
        inst_addr = r_pc_f;
        if (r_req_en && (r_state == S_FETCH)) begin
            inst_req = 1'b1;
        end
        if (r_kill) begin
            inst_addr = r_kill_addr;
        end
    end

    // ------------------------------------------------------------------
    // Fetch PC, kill tracking and one-entry stall buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_en    <= 1'b0;
            r_pc_f      <= RESET_PC;
            r_kill      <= 1'b0;
            r_kill_addr <= '0;
            r_buf       <= '0;
        end else begin
            r_req_en <= 1'b1;
            if (redirect_valid) begin
                r_pc_f <= redirect_pc;
                r_buf  <= '0;
                if (w_accept) begin
                    r_kill <= 1'b0;
                end else if (inst_req) begin
                    r_kill      <= 1'b1;
                    r_kill_addr <= inst_addr;
                end
            end else if (w_accept) begin
                if (r_kill) begin
                    r_kill <= 1'b0;
                end else begin
                    r_pc_f <= w_pc_f_plus4;
                    if (stall_d) begin
                        r_buf.instr <= inst_rdata;
                        r_buf.pc    <= r_pc_f;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // IF/ID pipeline register: flush > stall > new instruction > bubble
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_d   <= '0;
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (flush_d) begin
            r_instr_d <= '0;
            r_valid_d <= 1'b0;
        end else if (stall_d) begin
            r_instr_d   <= r_instr_d;
            r_pc_d      <= r_pc_d;
            r_pcplus4_d <= r_pcplus4_d;
            r_valid_d   <= r_valid_d;
        end else if (w_to_ifid) begin
            r_instr_d   <= inst_rdata;
            r_pc_d      <= r_pc_f;
            r_pcplus4_d <= w_pc_f_plus4;
            r_valid_d   <= 1'b1;
        end else if (w_drain) begin
            r_instr_d   <= r_buf.instr;
            r_pc_d      <= r_buf.pc;
            r_pcplus4_d <= w_buf_pc_plus4;
            r_valid_d   <= 1'b1;
        end else begin
            r_instr_d <= '0;
            r_valid_d <= 1'b0;
        end
    end

    assign instr_d   = r_instr_d;
    assign pc_d      = r_pc_d;
    assign pcplus4_d = r_pcplus4_d;
    assign valid_d   = r_valid_d;

endmodule
